// File: rtl/matmul_tile_scheduler_pkg.sv
// Shared types and helpers for the matmul tile scheduler and its address generators.
package matmul_tile_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must hold values 0..n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/matmul_tile_scheduler_tile_addr_gen.sv
// One valid/ready tile-address stream: addr = outer*STRIDE + inner, inner fastest.
module tile_addr_gen
  import matmul_tile_scheduler_pkg::*;
#(
  parameter int OUTER      = 2,
  parameter int INNER      = 3,
  parameter int STRIDE     = 3,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  launch,
  input  logic                  ready,
  output logic                  valid,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam int OW = cnt_width(OUTER);
  localparam int IW = cnt_width(INNER);
  localparam logic [OW-1:0] OUTER_LAST = OW'(OUTER - 1);
  localparam logic [IW-1:0] INNER_LAST = IW'(INNER - 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(STRIDE);

  logic [OW-1:0]         outer;
  logic [IW-1:0]         inner;
  logic [ADDR_WIDTH-1:0] base;
  logic                  inner_end;
  logic                  outer_end;

  assign inner_end = (inner == INNER_LAST);
  assign outer_end = (outer == OUTER_LAST);

  // base tracks outer*STRIDE so no multiplier is needed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      outer <= '0;
      inner <= '0;
      base  <= '0;
      addr  <= '0;
    end else if (launch) begin
      valid <= 1'b1;
      outer <= '0;
      inner <= '0;
      base  <= '0;
      addr  <= '0;
    end else if (valid && ready) begin
      if (inner_end) begin
        if (outer_end) begin
          valid <= 1'b0;
        end else begin
          outer <= outer + OW'(1);
          inner <= '0;
          base  <= base + STRIDE_A;
          addr  <= base + STRIDE_A;
        end
      end else begin
        inner <= inner + IW'(1);
        addr  <= addr + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/matmul_tile_scheduler.sv
// Issues in1/in2/bias tile-fetch addresses for one matmul and tracks output tiles to completion.
module matmul_tile_scheduler
  import matmul_tile_scheduler_pkg::*;
#(
  parameter int ITER_IN1_Y = 2,
  parameter int ITER_IN2_Y = 2,
  parameter int ITER_IN1_X = 3,
  parameter int HAS_BIAS   = 0,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] in1_addr,
  output logic                  in1_addr_valid,
  input  logic                  in1_addr_ready,
  output logic [ADDR_WIDTH-1:0] in2_addr,
  output logic                  in2_addr_valid,
  input  logic                  in2_addr_ready,
  output logic [ADDR_WIDTH-1:0] bias_addr,
  output logic                  bias_addr_valid,
  input  logic                  bias_addr_ready,
  input  logic                  mm_out_valid,
  input  logic                  mm_out_ready,
  output logic [ADDR_WIDTH-1:0] out_row,
  output logic [ADDR_WIDTH-1:0] out_col,
  output logic                  out_last
);

  localparam int RW = cnt_width(ITER_IN1_Y);
  localparam int CW = cnt_width(ITER_IN2_Y);
  localparam logic [RW-1:0] ROW_LAST = RW'(ITER_IN1_Y - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(ITER_IN2_Y - 1);

  state_t        state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          launch;
  logic          out_beat;
  logic          row_end;
  logic          col_end;

  assign launch   = start && (state == IDLE);
  assign out_beat = mm_out_valid && mm_out_ready && (state == RUN);
  assign row_end  = (row == ROW_LAST);
  assign col_end  = (col == COL_LAST);
  assign out_row  = ADDR_WIDTH'(row);
  assign out_col  = ADDR_WIDTH'(col);
  assign out_last = row_end && col_end && (state == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      row   <= '0;
      col   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            row   <= '0;
            col   <= '0;
          end
        end
        RUN: begin
          if (out_beat) begin
            if (col_end) begin
              col <= '0;
              if (row_end) begin
                row   <= '0;
                state <= DONE;
                done  <= 1'b1;
              end else begin
                row <= row + RW'(1);
              end
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  tile_addr_gen #(
    .OUTER(ITER_IN1_Y), .INNER(ITER_IN1_X), .STRIDE(ITER_IN1_X), .ADDR_WIDTH(ADDR_WIDTH)
  ) u_in1 (
    .clk(clk), .rst(rst), .launch(launch), .ready(in1_addr_ready),
    .valid(in1_addr_valid), .addr(in1_addr)
  );

  tile_addr_gen #(
    .OUTER(ITER_IN2_Y), .INNER(ITER_IN1_X), .STRIDE(ITER_IN1_X), .ADDR_WIDTH(ADDR_WIDTH)
  ) u_in2 (
    .clk(clk), .rst(rst), .launch(launch), .ready(in2_addr_ready),
    .valid(in2_addr_valid), .addr(in2_addr)
  );

  // With bias disabled the generator is never launched, so it idles at valid=0.
  tile_addr_gen #(
    .OUTER(ITER_IN1_Y), .INNER(ITER_IN2_Y), .STRIDE(ITER_IN2_Y), .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bias (
    .clk(clk), .rst(rst), .launch(launch && (HAS_BIAS != 0)), .ready(bias_addr_ready),
    .valid(bias_addr_valid), .addr(bias_addr)
  );

endmodule

// File: doc/matmul_tile_scheduler.md
MATMUL_TILE_SCHEDULER -- requirements
Module: matmul_tile_scheduler

Interface
REQ-001 Parameter ITER_IN1_Y, default 2: number of in1 row-block tiles.
REQ-002 Parameter ITER_IN2_Y, default 2: number of in2 row-block (output column-block) tiles.
REQ-003 Parameter ITER_IN1_X, default 3: number of reduction-depth tiles.
REQ-004 Parameter HAS_BIAS, default 0: 1 enables the bias address stream.
REQ-005 Parameter ADDR_WIDTH, default 16: width of every tile-address output.
REQ-006 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-007 Port rst, input, 1: asynchronous active-low reset.
REQ-008 Port start, input, 1: single-cycle request to run one full matmul.
REQ-009 Port busy, output, 1: high from start acceptance until done.
REQ-010 Port done, output, 1: one-cycle pulse when the final output tile is accepted.
REQ-011 Ports in1_addr (ADDR_WIDTH) and in1_addr_valid (1), outputs, plus in1_addr_ready (1), input: in1 tile-fetch stream.
REQ-012 Ports in2_addr (ADDR_WIDTH) and in2_addr_valid (1), outputs, plus in2_addr_ready (1), input: in2 tile-fetch stream.
REQ-013 Ports bias_addr (ADDR_WIDTH) and bias_addr_valid (1), outputs, plus bias_addr_ready (1), input: bias tile-fetch stream.
REQ-014 Ports mm_out_valid and mm_out_ready (1 each), inputs: monitored matmul output handshake.
REQ-015 Ports out_row and out_col (ADDR_WIDTH each) and out_last (1), outputs: tile index of the current output beat.

Function
REQ-016 FSM states: IDLE, RUN, DONE; start in IDLE moves to RUN, and start in RUN or DONE is ignored.
REQ-017 On start acceptance at cycle t: all enabled address valids rise at t+1, all stream counters clear, and busy rises at t+1.
REQ-018 in1 stream: addresses r*ITER_IN1_X+k in order r outer, k inner; ITER_IN1_Y*ITER_IN1_X beats total; each address is issued once.
REQ-019 in2 stream: addresses c*ITER_IN1_X+k in order c outer, k inner; ITER_IN2_Y*ITER_IN1_X beats total; each address is issued once, with repetition handled downstream.
REQ-020 Bias stream: addresses r*ITER_IN2_Y+c in order r outer, c inner; ITER_IN1_Y*ITER_IN2_Y beats total; bias_addr_valid stays 0 when HAS_BIAS=0.
REQ-021 Handshake rules, applied per stream: a beat transfers on valid&&ready; addr stays stable while valid&&!ready; valid never drops without a transfer; after its final beat the stream deasserts valid and holds addr.
REQ-022 Each stream advances independently, with no ordering dependency between streams.
REQ-023 Output tracker: out_row and out_col start at 0 and advance on mm_out_valid&&mm_out_ready, with col inner and wrap at ITER_IN2_Y; out_last = (row==ITER_IN1_Y-1)&&(col==ITER_IN2_Y-1).
REQ-024 Output transfers with out_last=1 move RUN to DONE; DONE asserts done for exactly one cycle, then returns to IDLE with busy=0.
REQ-025 mm_out handshakes seen in IDLE are ignored and the tracker does not move.
REQ-026 Counters are sized $clog2(N+1), and addresses are computed by incremental add rather than multipliers.

Reset
REQ-027 When rst is low, all outputs are 0 asynchronously, the FSM enters IDLE, and all counters clear, including mid-run.
REQ-028 After rst deasserts, no address valid rises until a new start.

Structure
REQ-029 A shared package holds the FSM state enum and a helper function for counter width.
REQ-030 One sub-module, tile_addr_gen, is instantiated per stream; it has outer/inner counts, stride, and a valid/ready address stream.

Verification
REQ-031 Defaults, start, all readies=1 -> in1 yields 0,1,2,3,4,5 and in2 yields 0,1,2,3,4,5 on consecutive cycles starting at t+1; bias_addr_valid stays 0.
REQ-032 HAS_BIAS=1 with bias_addr_ready toggling 1,0 -> bias yields 0,1,2,3; addr is stable on stall cycles; exactly 4 transfers.
REQ-033 Four mm_out beats with gaps -> out_row,col go (0,0),(0,1),(1,0),(1,1); out_last only on the 4th beat; done pulses one cycle later; busy falls with DONE exit.
REQ-034 A second start pulse mid-RUN -> no counter restart, and the address sequences are unchanged.
REQ-035 rst low after the 3rd in1 transfer -> all outputs are 0 immediately; after release plus start, in1 restarts at 0.
REQ-036 in1_addr_ready=0 for 10 cycles while in2 runs -> in2 completes its 6 beats, and in1 holds address 0 valid throughout.
